ctrl_sequencer: RTL

Multi-cycle control sequencer for the 8-bit datapath. It fetches instruction bytes, decodes them, and holds the program counter and instruction register. It drives the register-file addresses and ALU opcode, and generates the select for the 2-input write-back MUX: in[0] = ALU result, in[1] = `imm`, which this block also produces. It sits directly upstream of that MUX and is the only source of its select and immediate operand.

---
 rtl/ctrl_sequencer_if.sv | 34 +++
 rtl/ctrl_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/ctrl_sequencer_if.sv
// Control-sequencer bus: instruction memory port, ALU/register-file controls and status.
interface ctrl_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
);
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;
  logic             zero_flag;
  logic             mem_req;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] imm;
  logic [SEL_W-1:0] wb_sel;
  logic [2:0]       alu_op;
  logic [1:0]       reg_ra;
  logic [1:0]       reg_rb;
  logic [1:0]       reg_wa;
  logic             reg_we;
  logic             flags_we;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;

  modport master (
    input  mem_rdata, mem_ready, zero_flag,
    output mem_req, pc, imm, wb_sel, alu_op, reg_ra, reg_rb, reg_wa,
           reg_we, flags_we, state, halted, illegal
  );

  modport slave (
    output mem_rdata, mem_ready, zero_flag,
    input  mem_req, pc, imm, wb_sel, alu_op, reg_ra, reg_rb, reg_wa,
           reg_we, flags_we, state, halted, illegal
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit datapath.
// All outputs are Moore-decoded from state, IR and the latched immediate.
module ctrl_sequencer #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    FETCH_IMM = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t           state_q, state_d;
  logic [7:0]       ir_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] imm_q;
  logic             illegal_q;

  logic [3:0] op;
  logic [1:0] rd, rs;
  logic       two_byte, undef_op, is_alu;

  assign op       = ir_q[7:4];
  assign rd       = ir_q[3:2];
  assign rs       = ir_q[1:0];
  assign two_byte = (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
  assign undef_op = (op >= 4'h9) && (op <= 4'hE);
  assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: if (bus.mem_ready) begin
          ir_q <= bus.mem_rdata[7:0];
          pc_q <= pc_q + WIDTH'(1);
        end
        FETCH_IMM: if (bus.mem_ready) begin
          imm_q <= bus.mem_rdata;
          pc_q  <= pc_q + WIDTH'(1);
        end
        DECODE: if (undef_op) illegal_q <= 1'b1;
        EXECUTE: if ((op == OP_JMP) || ((op == OP_JZ) && bus.zero_flag)) pc_q <= imm_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        if (two_byte)                         state_d = FETCH_IMM;
        else if ((op == OP_HLT) || undef_op)  state_d = HALT;
        else if (op == OP_NOP)                state_d = FETCH;
        else                                  state_d = EXECUTE;
      end
      FETCH_IMM: if (bus.mem_ready) state_d = EXECUTE;
      // Only LDI/MOV/ALU/JMP/JZ can reach EXECUTE; branches skip write-back.
      EXECUTE:   state_d = ((op == OP_JMP) || (op == OP_JZ)) ? FETCH : WRITEBACK;
      WRITEBACK: state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.mem_req  = (state_q == FETCH) || (state_q == FETCH_IMM);
    bus.reg_we   = (state_q == WRITEBACK);
    bus.reg_wa   = (state_q == WRITEBACK) ? rd : '0;
    bus.wb_sel   = ((state_q == WRITEBACK) && (op == OP_LDI)) ? SEL_W'(1) : '0;
    bus.flags_we = (state_q == EXECUTE) && is_alu;
    bus.halted   = (state_q == HALT);
    bus.reg_ra   = rd;
    bus.reg_rb   = rs;
    bus.alu_op   = 3'd0;
    case (op)
      OP_ADD:  bus.alu_op = 3'd1;
      OP_SUB:  bus.alu_op = 3'd2;
      OP_AND:  bus.alu_op = 3'd3;
      OP_OR:   bus.alu_op = 3'd4;
      default: bus.alu_op = 3'd0;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.pc      = pc_q;
  assign bus.imm     = imm_q;
  assign bus.illegal = illegal_q;

endmodule
